crossing_ctrl: RTL and testbench
================================

CROSSING_CTRL -- requirements
Module: crossing_ctrl

Interface
REQ-001 SHALL have parameter T_GREEN_MIN, default 8, minimum main-road (A) green cycles.
REQ-002 SHALL have parameter T_B_GREEN, default 6, side-road (B) green cycles.
REQ-003 SHALL have parameter T_YELLOW, default 3, yellow cycles (both roads).
REQ-004 SHALL have parameter T_ALLRED, default 2, all-red clearance cycles.
REQ-005 SHALL have parameter T_REDYEL, default 2, red+yellow cycles before any green.
REQ-006 SHALL have parameter T_PED, default 5, pedestrian walk cycles; all parameters legal range 1..255.
REQ-007 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-008 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-009 SHALL have port car_b  input  1  level, vehicle waiting on road B.
REQ-010 SHALL have port ped_req  input  1  pedestrian button, any pulse width >= 1 cycle.
REQ-011 SHALL have ports red_a, yellow_a, green_a  output  1 each  road A lamps.
REQ-012 SHALL have ports red_b, yellow_b, green_b  output  1 each  road B lamps.
REQ-013 SHALL have port walk  output  1  pedestrian walk signal.
REQ-014 SHALL have port state  output  4  current state code (REQ-016).

Function
REQ-015 SHALL be a Moore FSM; all outputs registered or decoded from state only, no input-to-output combinational path.
REQ-016 States/codes: A_GREEN=0, A_YELLOW=1, ALL_RED1=2, B_REDYEL=3, B_GREEN=4, B_YELLOW=5, ALL_RED2=6, A_REDYEL=7, PED=8; codes 9-15 SHALL go to ALL_RED2 next cycle, timer 0.
REQ-017 Lamps: A_GREEN g_a; A_YELLOW y_a; A_REDYEL r_a+y_a; B_REDYEL r_b+y_b; B_GREEN g_b; B_YELLOW y_b; every state SHALL show red on each road not listed as green/yellow; walk=1 only in PED.
REQ-018 SHALL never assert a green or yellow on A and B in the same cycle.
REQ-019 8-bit timer SHALL be 0 in the first cycle of every state, increment each cycle, saturate at 255.
REQ-020 Fixed-length state of duration T SHALL last exactly T cycles (exit when timer==T-1).
REQ-021 Transitions: A_YELLOW->ALL_RED1; B_REDYEL->B_GREEN; B_GREEN->B_YELLOW; B_YELLOW->ALL_RED2; A_REDYEL->A_GREEN; PED->A_REDYEL.
REQ-022 A_GREEN->A_YELLOW when timer>=T_GREEN_MIN-1 and (car_b or ped_pending); otherwise stay indefinitely.
REQ-023 ALL_RED1 end: ->PED if ped_pending else ->B_REDYEL; ALL_RED2 end: ->PED if ped_pending else ->A_REDYEL.
REQ-024 ped_pending SHALL set on any cycle with ped_req=1 and clear on the cycle entering PED.
REQ-025 ped_req=1 in the cycle PED is entered SHALL be absorbed (pending stays 0); ped_req=1 in any later PED cycle SHALL set pending for the next cycle of service.
REQ-026 car_b deasserting after A_GREEN exit SHALL NOT abort the B phase.

Reset
REQ-027 rst=1 at a posedge SHALL force state=ALL_RED2, timer=0, ped_pending=0 on that edge, overriding any transition, incl. mid-phase.
REQ-028 During and after reset: red_a=1, red_b=1, all yellow/green=0, walk=0.
REQ-029 First cycle after rst release SHALL be ALL_RED2 timer=0; sequence then proceeds per REQ-023 (ped_req ignored while rst=1).

Verification
REQ-030 Reset release, car_b=0, ped_req=0 -> ALL_RED2 2 cycles, A_REDYEL 2, A_GREEN from cycle 4 held indefinitely.
REQ-031 car_b=1 from cycle 4 -> A_GREEN 8, A_YELLOW 3, ALL_RED1 2, B_REDYEL 2, B_GREEN 6, B_YELLOW 3, ALL_RED2 2, A_REDYEL 2, A_GREEN.
REQ-032 1-cycle ped_req during A_GREEN, car_b=0 -> after min green: A_YELLOW 3, ALL_RED1 2, PED 5 (walk=1, both red), A_REDYEL 2, A_GREEN; ped_pending=0.
REQ-033 ped_req during B_GREEN with car_b=1 -> B_YELLOW, ALL_RED2, PED 5, A_REDYEL; no B_REDYEL between.
REQ-034 rst=1 for 1 cycle mid-B_GREEN -> next cycle ALL_RED2 timer 0, g_b=0, pending cleared; sequence restarts per REQ-030.
REQ-035 Every bench cycle SHALL check REQ-018 and REQ-017 against the state code.

Source files
------------

// File: rtl/crossing_ctrl.sv
// Two-road crossing controller with pedestrian phase.
// Moore FSM: lamps and walk decode from the state register only.
module crossing_ctrl #(
    parameter int T_GREEN_MIN = 8,
    parameter int T_B_GREEN   = 6,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 2,
    parameter int T_REDYEL    = 2,
    parameter int T_PED       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car_b,
    input  logic       ped_req,
    output logic       red_a,
    output logic       yellow_a,
    output logic       green_a,
    output logic       red_b,
    output logic       yellow_b,
    output logic       green_b,
    output logic       walk,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        A_GREEN  = 4'd0,
        A_YELLOW = 4'd1,
        ALL_RED1 = 4'd2,
        B_REDYEL = 4'd3,
        B_GREEN  = 4'd4,
        B_YELLOW = 4'd5,
        ALL_RED2 = 4'd6,
        A_REDYEL = 4'd7,
        PED      = 4'd8
    } st_t;

    // Last-cycle timer values of each timed phase.
    localparam logic [7:0] GMIN_L = 8'(T_GREEN_MIN - 1);
    localparam logic [7:0] BG_L   = 8'(T_B_GREEN - 1);
    localparam logic [7:0] YEL_L  = 8'(T_YELLOW - 1);
    localparam logic [7:0] ARED_L = 8'(T_ALLRED - 1);
    localparam logic [7:0] RY_L   = 8'(T_REDYEL - 1);
    localparam logic [7:0] PED_L  = 8'(T_PED - 1);

    st_t        state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       pend_q, pend_d;
    logic       ped_first;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ALL_RED2;
            timer_q <= 8'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            A_GREEN:
                if (timer_q >= GMIN_L && (car_b || pend_q))
                    state_d = A_YELLOW;
            A_YELLOW:
                if (timer_q == YEL_L) state_d = ALL_RED1;
            ALL_RED1:
                if (timer_q == ARED_L) state_d = pend_q ? PED : B_REDYEL;
            B_REDYEL:
                if (timer_q == RY_L) state_d = B_GREEN;
            B_GREEN:
                if (timer_q == BG_L) state_d = B_YELLOW;
            B_YELLOW:
                if (timer_q == YEL_L) state_d = ALL_RED2;
            ALL_RED2:
                if (timer_q == ARED_L) state_d = pend_q ? PED : A_REDYEL;
            A_REDYEL:
                if (timer_q == RY_L) state_d = A_GREEN;
            PED:
                if (timer_q == PED_L) state_d = A_REDYEL;
            default:
                state_d = ALL_RED2;
        endcase
    end

    always_comb begin
        timer_d = 8'd0;
        if (state_d == state_q)
            timer_d = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
    end

    // A request landing on the PED entry edge or first PED cycle is served now.
    assign ped_first = (state_q == PED) && (timer_q == 8'd0);

    always_comb begin
        pend_d = pend_q;
        if (state_d == PED && state_q != PED)
            pend_d = 1'b0;
        else if (ped_req && !ped_first)
            pend_d = 1'b1;
    end

    always_comb begin
        red_a    = 1'b1;
        yellow_a = 1'b0;
        green_a  = 1'b0;
        red_b    = 1'b1;
        yellow_b = 1'b0;
        green_b  = 1'b0;
        walk     = 1'b0;
        case (state_q)
            A_GREEN: begin
                red_a   = 1'b0;
                green_a = 1'b1;
            end
            A_YELLOW: begin
                red_a    = 1'b0;
                yellow_a = 1'b1;
            end
            A_REDYEL: yellow_a = 1'b1;
            B_REDYEL: yellow_b = 1'b1;
            B_GREEN: begin
                red_b   = 1'b0;
                green_b = 1'b1;
            end
            B_YELLOW: begin
                red_b    = 1'b0;
                yellow_b = 1'b1;
            end
            PED:     walk = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_crossing_ctrl.sv
// Bench for crossing_ctrl: directed phase tables, corner sequences,
// and random traffic against a phase/age reference model.
module tb_crossing_ctrl;

    localparam int TG = 8;
    localparam int TB = 6;
    localparam int TY = 3;
    localparam int TR = 2;
    localparam int TRY = 2;
    localparam int TP = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       car_b = 1'b0;
    logic       ped_req = 1'b0;
    logic       red_a, yellow_a, green_a;
    logic       red_b, yellow_b, green_b;
    logic       walk;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    crossing_ctrl #(
        .T_GREEN_MIN(TG), .T_B_GREEN(TB), .T_YELLOW(TY),
        .T_ALLRED(TR), .T_REDYEL(TRY), .T_PED(TP)
    ) dut (
        .clk(clk), .rst(rst), .car_b(car_b), .ped_req(ped_req),
        .red_a(red_a), .yellow_a(yellow_a), .green_a(green_a),
        .red_b(red_b), .yellow_b(yellow_b), .green_b(green_b),
        .walk(walk), .state(state)
    );

    always #5 clk = ~clk;

    // Reference: phase index, unbounded age in phase, pending request.
    int m_phase = 6;
    int m_age = 0;
    bit m_pend = 1'b0;
    int dur[9];
    logic [6:0] lamp_tbl[9];

    typedef struct {
        bit rst;
        bit car;
        bit ped;
        int st;
        int len;
        int t0;
    } row_t;

    row_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit c, input bit p);
        bit leave;
        int nxt;
        bit np;
        if (r) begin
            m_phase = 6;
            m_age = 0;
            m_pend = 1'b0;
            return;
        end
        if (m_phase == 0) leave = (m_age >= TG - 1) && (c || m_pend);
        else leave = (m_age + 1 == dur[m_phase]);
        case (m_phase)
            0: nxt = 1;
            1: nxt = 2;
            2: nxt = m_pend ? 8 : 3;
            3: nxt = 4;
            4: nxt = 5;
            5: nxt = 6;
            6: nxt = m_pend ? 8 : 7;
            7: nxt = 0;
            default: nxt = 7;
        endcase
        np = m_pend;
        if (leave && nxt == 8) np = 1'b0;
        else if (p && !(m_phase == 8 && m_age == 0)) np = 1'b1;
        m_pend = np;
        if (leave) begin
            m_phase = nxt;
            m_age = 0;
        end else begin
            m_age++;
        end
    endtask

    task automatic check_all();
        logic [6:0] lamps;
        int exp_t;
        lamps = {red_a, yellow_a, green_a, red_b, yellow_b, green_b, walk};
        exp_t = (m_age > 255) ? 255 : m_age;
        chk("state", int'(state), m_phase);
        chk("lamps", int'(lamps), int'(lamp_tbl[m_phase]));
        chk("timer", int'(dut.timer_q), exp_t);
        chk("pending", int'(dut.pend_q), int'(m_pend));
        chk("conflict", int'((yellow_a | green_a) & (yellow_b | green_b)), 0);
    endtask

    task automatic step(input bit r, input bit c, input bit p);
        rst = r;
        car_b = c;
        ped_req = p;
        @(posedge clk);
        model_update(r, c, p);
        @(negedge clk);
        check_all();
    endtask

    task automatic row(input bit r, input bit c, input bit p,
                       input int st, input int len, input int t0);
        for (int i = 0; i < len; i++) begin
            step(r, c, p);
            chk("seq_state", int'(state), st);
            chk("seq_timer", int'(dut.timer_q), r ? 0 : t0 + i);
        end
    endtask

    initial begin
        dur[0] = 0;  dur[1] = TY; dur[2] = TR; dur[3] = TRY; dur[4] = TB;
        dur[5] = TY; dur[6] = TR; dur[7] = TRY; dur[8] = TP;
        lamp_tbl[0] = 7'b0011000;
        lamp_tbl[1] = 7'b0101000;
        lamp_tbl[2] = 7'b1001000;
        lamp_tbl[3] = 7'b1001100;
        lamp_tbl[4] = 7'b1000010;
        lamp_tbl[5] = 7'b1000100;
        lamp_tbl[6] = 7'b1001000;
        lamp_tbl[7] = 7'b1101000;
        lamp_tbl[8] = 7'b1001001;

        // Idle start-up, then a reset (with ignored inputs) and a full B cycle.
        tbl.push_back('{1'b1, 1'b0, 1'b0, 6, 2, 0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 6, 1, 1});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 7, 2, 0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 0, 20, 0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 6, 1, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 6, 1, 1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 7, 2, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 0, 8, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1, 3, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2, 2, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3, 2, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4, 6, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 5, 3, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 6, 2, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 7, 2, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 0, 8, 0});
        foreach (tbl[k])
            row(tbl[k].rst, tbl[k].car, tbl[k].ped,
                tbl[k].st, tbl[k].len, tbl[k].t0);

        // One-cycle pedestrian press during A green, no cars.
        row(1, 0, 0, 6, 1, 0);
        row(0, 0, 0, 6, 1, 1);
        row(0, 0, 0, 7, 2, 0);
        row(0, 0, 0, 0, 3, 0);
        step(0, 0, 1);
        chk("ped_set", int'(dut.pend_q), 1);
        row(0, 0, 0, 0, 4, 4);
        row(0, 0, 0, 1, 3, 0);
        row(0, 0, 0, 2, 2, 0);
        row(0, 0, 0, 8, TP, 0);
        chk("walk_ped", int'(walk), 1);
        row(0, 0, 0, 7, 2, 0);
        row(0, 0, 0, 0, 3, 0);
        chk("ped_clear", int'(dut.pend_q), 0);

        // Press during B green; car leaves mid-B phase.
        row(1, 0, 0, 6, 1, 0);
        row(0, 1, 0, 6, 1, 1);
        row(0, 1, 0, 7, 2, 0);
        row(0, 1, 0, 0, 8, 0);
        row(0, 1, 0, 1, 3, 0);
        row(0, 1, 0, 2, 2, 0);
        row(0, 0, 0, 3, 2, 0);
        row(0, 0, 0, 4, 2, 0);
        step(0, 0, 1);
        row(0, 0, 0, 4, 3, 3);
        row(0, 0, 0, 5, 3, 0);
        row(0, 0, 0, 6, 2, 0);
        row(0, 0, 0, 8, TP, 0);
        row(0, 0, 0, 7, 2, 0);
        row(0, 0, 0, 0, 3, 0);

        // Reset pulse mid B green with a request pending.
        row(1, 0, 0, 6, 1, 0);
        row(0, 1, 0, 6, 1, 1);
        row(0, 1, 0, 7, 2, 0);
        row(0, 1, 0, 0, 8, 0);
        row(0, 1, 0, 1, 3, 0);
        row(0, 1, 0, 2, 2, 0);
        row(0, 1, 0, 3, 2, 0);
        row(0, 1, 0, 4, 3, 0);
        step(0, 1, 1);
        step(1, 1, 0);
        chk("rst_state", int'(state), 6);
        chk("rst_gb", int'(green_b), 0);
        chk("rst_pend", int'(dut.pend_q), 0);
        row(0, 0, 0, 6, 1, 1);
        row(0, 0, 0, 7, 2, 0);
        row(0, 0, 0, 0, 10, 0);

        // Long idle green: timer must saturate, then exit on demand.
        for (int i = 0; i < 260; i++) step(0, 0, 0);
        chk("sat_timer", int'(dut.timer_q), 255);
        step(0, 1, 0);
        chk("sat_exit", int'(state), 1);

        // Random traffic.
        begin
            bit c = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 15) == 0) c = ~c;
                step($urandom_range(0, 299) == 0, c,
                     $urandom_range(0, 19) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
